// File: rtl/mips_hilo_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// mips_hilo_muldiv_unit_if
//   Request / write-back bundle between the execute stage and the HI/LO
//   multiply-divide unit.
//
//   master (execute stage) drives : i_valid, i_op, i_rs_dat, i_rt_dat, i_flush
//   slave  (HI/LO unit)    drives : o_ready, o_SPR_h_dat, o_SPR_h_val,
//                                   o_SPR_l_dat, o_SPR_l_val, o_div_zero
// ----------------------------------------------------------------------------
interface mips_hilo_muldiv_unit_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_op;
    logic [N-1:0] i_rs_dat;
    logic [N-1:0] i_rt_dat;
    logic         i_flush;
    logic [N-1:0] o_SPR_h_dat;
    logic         o_SPR_h_val;
    logic [N-1:0] o_SPR_l_dat;
    logic         o_SPR_l_val;
    logic         o_div_zero;

    modport master (
        output i_valid, i_op, i_rs_dat, i_rt_dat, i_flush,
        input  o_ready, o_SPR_h_dat, o_SPR_h_val, o_SPR_l_dat, o_SPR_l_val, o_div_zero
    );

    modport slave (
        input  i_valid, i_op, i_rs_dat, i_rt_dat, i_flush,
        output o_ready, o_SPR_h_dat, o_SPR_h_val, o_SPR_l_dat, o_SPR_l_val, o_div_zero
    );
endinterface

// File: rtl/mips_hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// mips_hilo_muldiv_unit
//   Multi-cycle HI/LO unit for the MIPS32 execute stage. Executes
//   MULT/MULTU/MADD/MADDU (MUL_LAT cycles), DIV/DIVU (restoring division,
//   N iterations plus one sign-fix cycle) and MTHI/MTLO (single edge).
//   Owns the HI/LO registers and strobes o_SPR_h_val / o_SPR_l_val for one
//   cycle after each update.
//
//   Parameters : N       operand / register width (even, >= 8)
//                MUL_LAT accept-to-update latency of multiplies (1..4)
//   Ports      : clk     rising-edge clock
//                rstn    asynchronous active-low reset
//                bus     mips_hilo_muldiv_unit_if.slave (request + write-back)
//
//   i_op: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//         100 MTHI, 101 MTLO, 110 MADD, 111 MADDU
// ----------------------------------------------------------------------------
module mips_hilo_muldiv_unit #(
    parameter int N       = 32,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    mips_hilo_muldiv_unit_if.slave   bus
);

    localparam int             CW       = $clog2(N + 2);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  MUL_LAST = CW'(MUL_LAT);
    localparam logic [CW-1:0]  DIV_LAST = CW'(N);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MADDU = 3'b111
    } op_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    op_t           op_q;
    logic [N-1:0]  rs_q, rt_q;          // raw operands, held for the whole op
    logic [N-1:0]  hi_q, lo_q;
    logic [N-1:0]  quo_q, rem_q, dvs_q; // restoring-division working registers
    logic          h_val_q, l_val_q, dz_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    op_t          req_op;
    logic         req_signed;
    logic         req_is_mul;
    logic         req_is_div;
    logic         accept;
    logic [N-1:0] rs_mag, rt_mag;

    assign req_op     = op_t'(bus.i_op);
    // Even opcodes are the signed variants (MTHI/MTLO don't care).
    assign req_signed = ~bus.i_op[0];
    assign req_is_mul = (req_op == OP_MULT) || (req_op == OP_MULTU) ||
                        (req_op == OP_MADD) || (req_op == OP_MADDU);
    assign req_is_div = (req_op == OP_DIV) || (req_op == OP_DIVU);
    // A flush in the same cycle as a request drops the request.
    assign accept     = bus.i_valid && (state_q == S_IDLE) && !bus.i_flush;

    // The divider works on magnitudes; signs are restored in S_FIX.
    assign rs_mag = (req_signed && bus.i_rs_dat[N-1]) ? -bus.i_rs_dat : bus.i_rs_dat;
    assign rt_mag = (req_signed && bus.i_rt_dat[N-1]) ? -bus.i_rt_dat : bus.i_rt_dat;

    // ------------------------------------------------------------------
    // Multiply datapath: extending both operands to 2N bits makes one
    // unsigned multiplier give the right low 2N bits for signed ops too.
    // ------------------------------------------------------------------
    logic           op_signed;
    logic [2*N-1:0] ext_a, ext_b, prod, mul_res;

    assign op_signed = ~op_q[0];
    assign ext_a     = {{N{op_signed & rs_q[N-1]}}, rs_q};
    assign ext_b     = {{N{op_signed & rt_q[N-1]}}, rt_q};
    assign prod      = ext_a * ext_b;
    // MADD/MADDU (op bit 2 set in S_MUL) accumulate into the live HI/LO.
    assign mul_res   = op_q[2] ? ({hi_q, lo_q} + prod) : prod;

    // ------------------------------------------------------------------
    // Division step and sign correction
    // ------------------------------------------------------------------
    logic [N:0]   partial, diff;
    logic         neg_quo, neg_rem, div_by_zero;
    logic [N-1:0] quo_fix, rem_fix;

    assign partial     = {rem_q, quo_q[N-1]};
    assign diff        = partial - {1'b0, dvs_q};
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign neg_quo     = op_signed && (rs_q[N-1] ^ rt_q[N-1]);
    assign neg_rem     = op_signed && rs_q[N-1];
    assign quo_fix     = neg_quo ? -quo_q : quo_q;
    assign rem_fix     = neg_rem ? -rem_q : rem_q;
    assign div_by_zero = (rt_q == '0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic mul_done, div_done;

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d  = state_q;
        mul_done = 1'b0;
        div_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && req_is_mul)      state_d = S_MUL;
                else if (accept && req_is_div) state_d = S_DIV;
            end
            S_MUL: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    state_d  = S_IDLE;
                    mul_done = 1'b1;
                end
            end
            S_DIV: begin
                if (bus.i_flush)            state_d = S_IDLE;
                else if (cnt_q == DIV_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d  = S_IDLE;
                div_done = !bus.i_flush;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            h_val_q <= 1'b0;
            l_val_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            h_val_q <= 1'b0;
            l_val_q <= 1'b0;
            dz_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= req_op;
                        rs_q  <= bus.i_rs_dat;
                        rt_q  <= bus.i_rt_dat;
                        cnt_q <= CNT_ONE;
                        quo_q <= rs_mag;
                        dvs_q <= rt_mag;
                        rem_q <= '0;
                        if (req_op == OP_MTHI) begin
                            hi_q    <= bus.i_rs_dat;
                            h_val_q <= 1'b1;
                        end
                        if (req_op == OP_MTLO) begin
                            lo_q    <= bus.i_rs_dat;
                            l_val_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (mul_done) begin
                        {hi_q, lo_q} <= mul_res;
                        h_val_q      <= 1'b1;
                        l_val_q      <= 1'b1;
                    end
                end
                S_DIV: begin
                    // One quotient bit per cycle; restore when the trial
                    // subtraction goes negative.
                    cnt_q <= cnt_q + CNT_ONE;
                    rem_q <= diff[N] ? partial[N-1:0] : diff[N-1:0];
                    quo_q <= {quo_q[N-2:0], ~diff[N]};
                end
                S_FIX: begin
                    if (div_done) begin
                        if (div_by_zero) begin
                            lo_q <= '1;
                            hi_q <= rs_q;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                        h_val_q <= 1'b1;
                        l_val_q <= 1'b1;
                        dz_q    <= div_by_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_ready     = (state_q == S_IDLE);
    assign bus.o_SPR_h_dat = hi_q;
    assign bus.o_SPR_h_val = h_val_q;
    assign bus.o_SPR_l_dat = lo_q;
    assign bus.o_SPR_l_val = l_val_q;
    assign bus.o_div_zero  = dz_q;

endmodule

// File: tb/tb_mips_hilo_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_mips_hilo_muldiv_unit
//   Scoreboard bench for mips_hilo_muldiv_unit (N=32, MUL_LAT=2). Expected
//   HI/LO, strobes and latency are computed by a behavioural model when an
//   op is driven and compared when the write-back strobe appears. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mips_hilo_muldiv_unit;

    localparam int N       = 32;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mips_hilo_muldiv_unit_if #(.N(N)) bus ();

    mips_hilo_muldiv_unit #(.N(N), .MUL_LAT(MUL_LAT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        hv;
        logic        lv;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hi_m, lo_m;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural reference; updates the HI/LO model.
    task automatic model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            output exp_t e);
        logic signed [63:0] a, b, q, r;
        logic [63:0] p;
        e.hi  = hi_m;
        e.lo  = lo_m;
        e.hv  = 1'b1;
        e.lv  = 1'b1;
        e.dz  = 1'b0;
        e.lat = MUL_LAT;
        case (op)
            3'b000, 3'b110: begin
                a = {{32{rs[31]}}, rs};
                b = {{32{rt[31]}}, rt};
                p = a * b;
                if (op == 3'b110) p = p + {hi_m, lo_m};
                {e.hi, e.lo} = p;
            end
            3'b001, 3'b111: begin
                p = {32'b0, rs} * {32'b0, rt};
                if (op == 3'b111) p = p + {hi_m, lo_m};
                {e.hi, e.lo} = p;
            end
            3'b010, 3'b011: begin
                e.lat = N + 1;
                if (rt == 32'd0) begin
                    e.hi = rs;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else begin
                    if (op == 3'b010) begin
                        a = {{32{rs[31]}}, rs};
                        b = {{32{rt[31]}}, rt};
                    end else begin
                        a = {32'b0, rs};
                        b = {32'b0, rt};
                    end
                    q = a / b;
                    r = a % b;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            3'b100: begin
                e.hi  = rs;
                e.lv  = 1'b0;
                e.lat = 0;
            end
            default: begin
                e.lo  = rs;
                e.hv  = 1'b0;
                e.lat = 0;
            end
        endcase
        hi_m = e.hi;
        lo_m = e.lo;
    endtask

    // Issue one op from a falling edge with the unit idle, then wait
    // (bounded) for its write-back and compare against the scoreboard.
    task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input string tag);
        exp_t e;
        int   cyc;
        int   rdy_low;
        check({tag, ".ready_in"}, bus.o_ready, 1);
        model_op(op, rs, rt, e);
        sb.push_back(e);
        bus.i_valid  = 1'b1;
        bus.i_op     = op;
        bus.i_rs_dat = rs;
        bus.i_rt_dat = rt;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_op     = 3'($urandom);
        bus.i_rs_dat = $urandom;
        bus.i_rt_dat = $urandom;
        cyc     = 0;
        rdy_low = 0;
        while (!(bus.o_SPR_h_val || bus.o_SPR_l_val) && cyc < 100) begin
            if (!bus.o_ready) rdy_low++;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".done"}, bus.o_SPR_h_val | bus.o_SPR_l_val, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".latency"},   cyc,               e.lat);
            check({tag, ".ready_low"}, rdy_low,           e.lat);
            check({tag, ".ready_out"}, bus.o_ready,       1);
            check({tag, ".hi"},        bus.o_SPR_h_dat,   e.hi);
            check({tag, ".lo"},        bus.o_SPR_l_dat,   e.lo);
            check({tag, ".h_val"},     bus.o_SPR_h_val,   e.hv);
            check({tag, ".l_val"},     bus.o_SPR_l_val,   e.lv);
            check({tag, ".div_zero"},  bus.o_div_zero,    e.dz);
        end
    endtask

    // n cycles with no strobe of any kind expected.
    task automatic quiet(input int n, input string tag);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (bus.o_SPR_h_val || bus.o_SPR_l_val || bus.o_div_zero) seen = 1'b1;
        end
        check({tag, ".no_pulse"}, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_rs, r_rt;

        bus.i_valid  = 1'b0;
        bus.i_op     = 3'b000;
        bus.i_rs_dat = '0;
        bus.i_rt_dat = '0;
        bus.i_flush  = 1'b0;
        hi_m = '0;
        lo_m = '0;
        rstn = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.hi",       bus.o_SPR_h_dat, 0);
        check("rst.lo",       bus.o_SPR_l_dat, 0);
        check("rst.ready",    bus.o_ready,     1);
        check("rst.h_val",    bus.o_SPR_h_val, 0);
        check("rst.l_val",    bus.o_SPR_l_val, 0);
        check("rst.div_zero", bus.o_div_zero,  0);
        rstn = 1'b1;
        @(negedge clk);

        // Multiplies, back-to-back accumulate
        do_op(3'b000, 32'hFFFF_FFFD, 32'd5,        "mult_neg");
        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        do_op(3'b111, 32'd2,         32'd3,        "maddu_b2b");
        quiet(1, "pulse_width");
        do_op(3'b110, 32'hFFFF_FFFF, 32'd1,        "madd_neg");

        // Divides, including overflow and divide-by-zero
        do_op(3'b011, 32'd100,       32'd7,        "divu_100_7");
        do_op(3'b010, 32'hFFFF_FFF9, 32'd2,        "div_m7_2");
        do_op(3'b010, 32'd7,         32'hFFFF_FFFE, "div_7_m2");
        do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(3'b010, 32'h0000_1234, 32'd0,        "div_zero");
        do_op(3'b011, 32'hFFFF_FFFF, 32'd0,        "divu_zero");
        do_op(3'b011, 32'hFFFF_FFFF, 32'd1,        "divu_max_1");

        // Moves
        do_op(3'b101, 32'h1234_5678, 32'd0,        "mtlo");

        // Random mix
        for (int i = 0; i < 10; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_rs = $urandom;
            r_rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_op(r_op, r_rs, r_rt, $sformatf("rand%0d", i));
        end

        do_op(3'b100, 32'hA5A5_A5A5, 32'd0,        "mthi");

        // Flush in the middle of a divide
        check("flush_div.ready_in", bus.o_ready, 1);
        bus.i_valid  = 1'b1;
        bus.i_op     = 3'b010;
        bus.i_rs_dat = 32'd100;
        bus.i_rt_dat = 32'd7;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_div.ready", bus.o_ready,     1);
        check("flush_div.h_val", bus.o_SPR_h_val, 0);
        check("flush_div.hi",    bus.o_SPR_h_dat, hi_m);
        check("flush_div.lo",    bus.o_SPR_l_dat, lo_m);
        quiet(40, "flush_div");

        // Flush on the exact completion edge of a multiply
        bus.i_valid  = 1'b1;
        bus.i_op     = 3'b001;
        bus.i_rs_dat = 32'd3;
        bus.i_rt_dat = 32'd3;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_cmp.ready", bus.o_ready,     1);
        check("flush_cmp.h_val", bus.o_SPR_h_val, 0);
        check("flush_cmp.hi",    bus.o_SPR_h_dat, hi_m);
        check("flush_cmp.lo",    bus.o_SPR_l_dat, lo_m);
        quiet(5, "flush_cmp");

        // Flush together with a request in IDLE
        bus.i_valid  = 1'b1;
        bus.i_flush  = 1'b1;
        bus.i_op     = 3'b100;
        bus.i_rs_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        check("flush_idle.h_val", bus.o_SPR_h_val, 0);
        check("flush_idle.hi",    bus.o_SPR_h_dat, hi_m);
        quiet(3, "flush_idle");

        do_op(3'b001, 32'd7, 32'd6, "post_flush");

        // Asynchronous reset during a divide
        bus.i_valid  = 1'b1;
        bus.i_op     = 3'b011;
        bus.i_rs_dat = 32'd100;
        bus.i_rt_dat = 32'd7;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("arst.hi",    bus.o_SPR_h_dat, 0);
        check("arst.lo",    bus.o_SPR_l_dat, 0);
        check("arst.ready", bus.o_ready,     1);
        check("arst.h_val", bus.o_SPR_h_val, 0);
        hi_m = '0;
        lo_m = '0;
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        quiet(35, "arst_lost");
        do_op(3'b000, 32'd2, 32'd2, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
